// File: rtl/bcd_pkg.sv
// Shared constants and types for the BCD scan decoder.
package bcd_pkg;
    localparam int BCD_W   = 4;
    localparam int BCD_MAX = 9;
    localparam int DEC_W   = 10;

    typedef logic [BCD_W-1:0] bcd_t;
    typedef logic [DEC_W-1:0] dec_t;
endpackage

// File: rtl/bcd_onehot_dec.sv
// Combinational 4-bit BCD code to 10-bit one-hot decimal, with a valid flag.
// Codes 10..15 produce an all-zero one-hot and valid=0.
module bcd_onehot_dec
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] i_code,
    output logic [DEC_W-1:0] o_onehot,
    output logic             o_valid
);
    // Compare against every decimal value so no out-of-range bit select exists
    always_comb begin
        o_onehot = '0;
        for (int k = 0; k < DEC_W; k++)
            o_onehot[k] = (i_code == BCD_W'(k));
        o_valid = (i_code <= BCD_W'(BCD_MAX));
    end
endmodule

// File: rtl/bcd_scan_decoder.sv
// Time-multiplexed BCD-to-decimal decoder for multi-digit displays.
// All outputs are registered from next-state index/data, so a LOAD or an
// index advance is visible right after the edge that performs it.
module bcd_scan_decoder
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_load,
    input  logic [BCD_W*DIGITS-1:0] i_din,
    input  logic                    i_lzb,
    input  logic                    i_clr_err,
    output logic [DIGITS-1:0]       o_sel,
    output logic [DEC_W-1:0]        o_d,
    output logic                    o_invalid,
    output logic                    o_err,
    output logic                    o_frame
);
    localparam int IDX_W = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [DIGITS-1:0][BCD_W-1:0] r_data;
    logic [CNT_W-1:0]             r_cnt;
    logic [IDX_W-1:0]             r_idx;

    logic [DIGITS-1:0][BCD_W-1:0] w_din;
    logic [DIGITS-1:0][BCD_W-1:0] w_data_nxt;
    logic [CNT_W-1:0]             w_cnt_nxt;
    logic [IDX_W-1:0]             w_idx_nxt;
    logic                         w_wrap;
    logic                         w_load_bad;
    logic [DIGITS:0]              w_zero_up;
    logic [DIGITS-1:0]            w_sel;
    bcd_t                         w_cur;
    logic                         w_blank;
    dec_t                         w_onehot;
    logic                         w_valid;

    assign w_din      = i_din;
    assign w_data_nxt = i_load ? w_din : r_data;

    // Prescaler and scan index next state; wrap marks the frame boundary
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_idx_nxt = r_idx;
        w_wrap    = 1'b0;
        if (i_en) begin
            if (r_cnt == CNT_W'(PRESCALE - 1)) begin
                w_cnt_nxt = '0;
                if (r_idx == IDX_W'(DIGITS - 1)) begin
                    w_idx_nxt = '0;
                    w_wrap    = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    // Any digit above 9 in the incoming word flags a load error
    always_comb begin
        w_load_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (w_din[i] > BCD_W'(BCD_MAX)) w_load_bad = 1'b1;
    end

    // w_zero_up[i]: digits i..DIGITS-1 of the next-state word are all zero
    always_comb begin
        w_zero_up[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--)
            w_zero_up[i] = w_zero_up[i+1] & (w_data_nxt[i] == '0);
    end

    // Select active digit, its blanking state and one-hot select by compare
    always_comb begin
        w_cur   = '0;
        w_blank = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_idx_nxt == IDX_W'(i)) begin
                w_sel[i] = 1'b1;
                w_cur    = w_data_nxt[i];
                // Digit 0 always shows so a zero value is never fully dark
                w_blank  = i_lzb && (i != 0) && w_zero_up[i];
            end
        end
    end

    bcd_onehot_dec u_dec (
        .i_code   (w_cur),
        .o_onehot (w_onehot),
        .o_valid  (w_valid)
    );

    // State and registered outputs; reset overrides everything
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data    <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
            o_sel     <= '0;
            o_d       <= '0;
            o_invalid <= 1'b0;
            o_err     <= 1'b0;
            o_frame   <= 1'b0;
        end else begin
            r_data    <= w_data_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            o_sel     <= w_sel;
            o_d       <= (w_blank || !w_valid) ? '0 : w_onehot;
            o_invalid <= !w_blank && !w_valid;
            o_frame   <= w_wrap;
            // A new error outranks a simultaneous clear
            o_err     <= (i_load && w_load_bad) || (o_err && !i_clr_err);
        end
    end
endmodule

// File: tb/tb_bcd_scan_decoder.sv
// Directed self-checking bench: DIGITS=4/PRESCALE=4 main instance plus a
// DIGITS=1/PRESCALE=1 instance sharing the same controls.
module tb_bcd_scan_decoder;
    logic        clk = 1'b0;
    logic        rst, en, load, lzb, clr_err;
    logic [15:0] din;

    logic [3:0]  sel;
    logic [9:0]  d;
    logic        invalid, err, frame;

    logic [0:0]  s_sel;
    logic [9:0]  s_d;
    logic        s_invalid, s_err, s_frame;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_scan_decoder #(.DIGITS(4), .PRESCALE(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_load(load), .i_din(din),
        .i_lzb(lzb), .i_clr_err(clr_err),
        .o_sel(sel), .o_d(d), .o_invalid(invalid), .o_err(err), .o_frame(frame)
    );

    bcd_scan_decoder #(.DIGITS(1), .PRESCALE(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_load(load), .i_din(din[3:0]),
        .i_lzb(lzb), .i_clr_err(clr_err),
        .o_sel(s_sel), .o_d(s_d), .o_invalid(s_invalid), .o_err(s_err), .o_frame(s_frame)
    );

    // One clock edge; outputs are stable 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; en = 0; load = 0; lzb = 0; clr_err = 0; din = '0;
        step(); step();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1;
        step();
        total++;
        if ({sel, d, invalid, err, frame} !== 17'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {sel, d, invalid, err, frame});
        end
        total++;
        if ({s_sel, s_d, s_invalid, s_err, s_frame} !== 14'd0) begin
            bad++;
            $display("FAIL reset_outputs_d1 got=%h want=0", {s_sel, s_d, s_invalid, s_err, s_frame});
        end
        rst = 0;
        step();
        total++;
        if (sel !== 4'b0001 || d !== 10'd1 || invalid !== 1'b0) begin
            bad++;
            $display("FAIL first_after_reset sel=%b d=%b inv=%b want sel=0001 d=1", sel, d, invalid);
        end
    endtask

    task automatic test_scan();
        logic [9:0] exp_d [4];
        logic [3:0] exp_sel;
        int         idx;
        exp_d[0] = 10'b1 << 4; exp_d[1] = 10'b1 << 3;
        exp_d[2] = 10'b1 << 2; exp_d[3] = 10'b1 << 1;
        do_reset();
        en = 1; load = 1; din = 16'h1234;
        for (int k = 0; k < 20; k++) begin
            step();
            load = 0;
            // after edge k the count is (k+1)%4 and index is ((k+1)/4)%4
            idx     = ((k + 1) / 4) % 4;
            exp_sel = 4'b1 << idx;
            total++;
            if (sel !== exp_sel || d !== exp_d[idx] || frame !== ((k + 1) % 16 == 0) || err !== 1'b0) begin
                bad++;
                $display("FAIL scan k=%0d sel=%b d=%b frame=%b err=%b want sel=%b d=%b frame=%0d",
                         k, sel, d, frame, err, exp_sel, exp_d[idx], ((k + 1) % 16 == 0));
            end
        end
    endtask

    task automatic test_lzb();
        logic [9:0] exp_d;
        int         idx;
        do_reset();
        en = 1; load = 1; din = 16'h0070; lzb = 1;
        for (int k = 0; k < 32; k++) begin
            if (k == 16) lzb = 0;
            step();
            load = 0;
            idx = ((k + 1) / 4) % 4;
            case (idx)
                0:       exp_d = 10'b1;
                1:       exp_d = 10'b1 << 7;
                default: exp_d = (k < 16) ? 10'd0 : 10'b1;
            endcase
            total++;
            if (sel !== (4'b1 << idx) || d !== exp_d || invalid !== 1'b0) begin
                bad++;
                $display("FAIL lzb k=%0d sel=%b d=%b inv=%b want sel=%b d=%b inv=0",
                         k, sel, d, invalid, 4'b1 << idx, exp_d);
            end
        end
    endtask

    task automatic test_err();
        do_reset();
        load = 1; din = 16'h00A5;
        step();
        load = 0;
        total++;
        if (err !== 1'b1 || sel !== 4'b0001 || d !== (10'b1 << 5)) begin
            bad++;
            $display("FAIL err_set err=%b sel=%b d=%b want err=1 sel=0001 d=%b", err, sel, d, 10'b1 << 5);
        end
        en = 1;
        repeat (4) step();
        en = 0;
        total++;
        if (sel !== 4'b0010 || d !== 10'd0 || invalid !== 1'b1) begin
            bad++;
            $display("FAIL invalid_digit sel=%b d=%b inv=%b want sel=0010 d=0 inv=1", sel, d, invalid);
        end
        clr_err = 1;
        step();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_clear got=%b want=0", err);
        end
        load = 1; din = 16'h0012;
        step();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_valid_load got=%b want=0", err);
        end
        din = 16'hF000;
        step();
        load = 0; clr_err = 0;
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_set_beats_clr got=%b want=1", err);
        end
        step();
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky got=%b want=1", err);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        en = 1; load = 1; din = 16'h1234;
        step();
        load = 0;
        step();
        en = 0;
        for (int k = 0; k < 10; k++) begin
            load = (k == 5);
            din  = 16'h9999;
            step();
            total++;
            if (sel !== 4'b0001) begin
                bad++;
                $display("FAIL freeze_sel k=%0d got=%b want=0001", k, sel);
            end
            if (k == 5) begin
                total++;
                if (d !== (10'b1 << 9)) begin
                    bad++;
                    $display("FAIL freeze_load d=%b want=%b", d, 10'b1 << 9);
                end
            end
        end
        load = 0;
        en = 1;
        step();
        total++;
        if (sel !== 4'b0001) begin
            bad++;
            $display("FAIL resume_hold sel=%b want=0001", sel);
        end
        step();
        total++;
        if (sel !== 4'b0010 || d !== (10'b1 << 9)) begin
            bad++;
            $display("FAIL resume_adv sel=%b d=%b want sel=0010 d=%b", sel, d, 10'b1 << 9);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        en = 1; load = 1; din = 16'h1234;
        step();
        load = 0;
        repeat (8) step();
        total++;
        if (sel !== 4'b0100 || d !== (10'b1 << 2)) begin
            bad++;
            $display("FAIL pre_rst sel=%b d=%b want sel=0100 d=%b", sel, d, 10'b1 << 2);
        end
        rst = 1; load = 1; din = 16'hA000; clr_err = 0;
        step();
        rst = 0; load = 0;
        total++;
        if ({sel, d, invalid, err, frame} !== 17'd0) begin
            bad++;
            $display("FAIL rst_mid got=%h want=0", {sel, d, invalid, err, frame});
        end
        step();
        total++;
        if (sel !== 4'b0001 || d !== 10'd1) begin
            bad++;
            $display("FAIL post_rst sel=%b d=%b want sel=0001 d=1", sel, d);
        end
    endtask

    task automatic test_digits1();
        do_reset();
        en = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            total++;
            if (s_sel !== 1'b1 || s_frame !== 1'b1 || s_d !== 10'd1) begin
                bad++;
                $display("FAIL d1_scan k=%0d sel=%b frame=%b d=%b want sel=1 frame=1 d=1",
                         k, s_sel, s_frame, s_d);
            end
        end
        load = 1; din = 16'h0003;
        step();
        load = 0;
        total++;
        if (s_d !== (10'b1 << 3) || s_frame !== 1'b1) begin
            bad++;
            $display("FAIL d1_load d=%b frame=%b want d=%b frame=1", s_d, s_frame, 10'b1 << 3);
        end
        en = 0;
        step();
        total++;
        if (s_frame !== 1'b0 || s_sel !== 1'b1) begin
            bad++;
            $display("FAIL d1_frozen frame=%b sel=%b want frame=0 sel=1", s_frame, s_sel);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lzb();
        test_err();
        test_freeze();
        test_rst_mid();
        test_digits1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_scan_decoder.md
# bcd_scan_decoder

Parametrised, time-multiplexed BCD-to-decimal decoder for multi-digit displays. Holds a DIGITS-wide packed BCD word, scans one digit at a time at a programmable rate, and drives a one-hot digit select plus a registered one-hot decimal output for the active digit. Adds invalid-code detection, a sticky load error, optional leading-zero blanking and a frame pulse. Sits between the counter/arith datapath and the display driver.

## Interface
- DIGITS, 4, number of BCD digits (≥1); digit 0 = DIN[3:0] = least significant
- PRESCALE, 4, enabled cycles each digit is shown (≥1)

- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- EN  in  1  scan enable; prescaler advances only when 1
- LOAD  in  1  capture DIN into digit register this cycle
- DIN  in  4*DIGITS  packed BCD input
- LZB  in  1  leading-zero blanking enable
- CLR_ERR  in  1  clears ERR
- SEL  out  DIGITS  one-hot active digit select
- D  out  10  one-hot decimal of active digit; all-zero when blanked or invalid
- INVALID  out  1  active digit code is 10..15
- ERR  out  1  sticky: a LOAD contained any code >9
- FRAME  out  1  one-cycle pulse when scan wraps DIGITS-1 -> 0

## Operation
- Reset: digit register = 0, prescale count = 0, index = 0; SEL, D, INVALID, ERR, FRAME = 0.
- LOAD=1: digit register <= DIN (no validity filtering; invalid codes are stored).
- ERR set on LOAD when any digit of DIN >9; cleared by CLR_ERR; set wins over CLR_ERR in the same cycle.
- Prescaler: when EN, count increments; at count = PRESCALE-1 it returns to 0 and index advances. EN=0 freezes count and index; outputs still refresh from stored data.
- Index wraps DIGITS-1 -> 0; the wrap cycle registers FRAME=1 for exactly one cycle. DIGITS=1: index stays 0, FRAME pulses every PRESCALE enabled cycles.
- Blanking: digit i (i≠0) blanked when LZB=1 and digits i..DIGITS-1 are all 0. Digit 0 never blanked. Blanked digit: D=0, INVALID=0, SEL still asserted.
- Invalid code on active digit: D=0, INVALID=1.
- Valid code k: D[k]=1, all other D bits 0.

## Timing
- SEL, D, INVALID, FRAME, ERR are registered; every non-reset cycle they reflect the next-state index and next-state digit register (i.e. the values being written this edge), so LOAD data or index advance appears on outputs after one clock edge.
- First cycle after RST deasserts: SEL=…0001, D reflects digit 0 (D[0]=1 after reset contents).
- LOAD and index advance in the same cycle: outputs show the new index with new data.
- RST mid-scan: next edge forces all reset values regardless of EN/LOAD/CLR_ERR.
- Index and count widths: $clog2 of DIGITS and PRESCALE, minimum 1 bit.

## Structure
- Shared package bcd_pkg: BCD_W=4, BCD_MAX=9, DEC_W=10.
- One sub-module: bcd_onehot_dec — combinational 4-bit code -> 10-bit one-hot plus valid flag; instantiated once on the selected digit.
- Top holds digit register, prescaler, index, blanking logic, output registers.

## Test plan
- DIGITS=4, PRESCALE=4: reset, EN=1, LOAD DIN=16'h1234 -> SEL cycles 0001,0010,0100,1000 every 4 cycles, D = one-hot 4,3,2,1; FRAME high one cycle on each 1000->0001 wrap.
- LOAD 16'h0070, LZB=1 -> digit 0 D[0]=1, digit 1 D[7]=1, digits 2,3 D=0 with SEL asserted; LZB=0 -> digits 2,3 show D[0]=1.
- LOAD 16'h00A5 -> ERR=1 next cycle; digit 1 shows D=0, INVALID=1; CLR_ERR -> ERR=0; CLR_ERR with LOAD of 16'hF000 same cycle -> ERR stays 1.
- EN=0 for 10 cycles mid-digit -> SEL constant; LOAD 16'h9999 during freeze -> D[9]=1 one cycle later.
- RST asserted while SEL=0100 -> next cycle all outputs 0, then SEL=0001, D[0]=1.
- DIGITS=1, PRESCALE=1, EN=1 -> SEL=1 constant, FRAME=1 every cycle.
